multireceive: RTL and testbench

//   Receiver matching the multisend digit link. Watches the 3-bit data lines and the control

---
 rtl/multireceive.sv | 225 ++++++++++++++++++++++
 tb/tb_multireceive.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multireceive.sv
// Receiver for the multisend digit link: synchronises the strobe and symbol lines, qualifies
// each strobe edge and rebuilds a decimal value from NUM_DIGITS symbols, LSD first.
// Optional inter-symbol timeout is compiled in with `define MULTIRECEIVE_TIMEOUT_EN.
module multireceive #(
    parameter int NUM_DIGITS     = 6,
    parameter int QUAL_CYCLES    = 1200,
    parameter int TIMEOUT_CYCLES = 2400000
) (
    input  logic        hwclk,
    input  logic        rst_n,
    input  logic        enabled,
    input  logic        in0,
    input  logic        in1,
    input  logic        in2,
    input  logic        controlIn,
    output logic [31:0] num,
    output logic        done,
    output logic        busy,
    output logic [2:0]  digit_cnt,
    output logic        err
);

    localparam int QW = $clog2(QUAL_CYCLES + 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 9 || QUAL_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("multireceive: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        QUAL_HIGH,
        WAIT_LOW,
        QUAL_LOW
    } state_t;

    logic [3:0]    sync1_q, sync2_q;
    logic [2:0]    sym;
    logic          ctl;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [2:0]    sym_lat_q, sym_lat_d;
    logic [31:0]   accum_q, accum_d;
    logic [31:0]   weight_q, weight_d;
    // Four bits so NUM_DIGITS up to 9 can be counted; only the low three leave the block.
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   num_q, num_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          accept;

`ifdef MULTIRECEIVE_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap_q, gap_d;
    logic          err_q, err_d;
`endif

    // Two-flop synchronisers for the asynchronous remote lines {ctl, sym[2:0]}.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so sync2_q takes the old sync1_q, giving two stages.
            sync1_q <= {controlIn, in2, in1, in0};
            sync2_q <= sync1_q;
        end
    end

    assign sym = sync2_q[2:0];
    assign ctl = sync2_q[3];

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        sym_lat_d = sym_lat_q;
        accum_d   = accum_q;
        weight_d  = weight_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        accept    = 1'b0;
`ifdef MULTIRECEIVE_TIMEOUT_EN
        gap_d     = '0;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                accum_d  = '0;
                weight_d = 32'd1;
                cnt_d    = '0;
                busy_d   = 1'b0;
                if (enabled) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (ctl) begin
                    state_d   = QUAL_HIGH;
                    qcnt_d    = QW'(1);
                    sym_lat_d = sym;
                end
            end
            QUAL_HIGH: begin
                if (!ctl) begin
                    state_d = WAIT_HIGH;
                end else if (sym != sym_lat_q) begin
                    sym_lat_d = sym;
                    qcnt_d    = QW'(1);
                end else if (qcnt_q == QW'(QUAL_CYCLES - 1)) begin
                    // This cycle is the QUAL_CYCLES-th stable one: take the symbol.
                    accept   = 1'b1;
                    accum_d  = accum_q + ({29'd0, sym} * weight_q);
                    weight_d = weight_q * 32'd10;
                    cnt_d    = cnt_q + 4'd1;
                    busy_d   = 1'b1;
                    state_d  = WAIT_LOW;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!ctl) begin
                    state_d = QUAL_LOW;
                    qcnt_d  = QW'(1);
                end
            end
            QUAL_LOW: begin
                if (ctl) begin
                    state_d = WAIT_LOW;
                end else if (qcnt_q == QW'(QUAL_CYCLES - 1)) begin
                    state_d = WAIT_HIGH;
                    if (cnt_q == 4'(NUM_DIGITS)) begin
                        num_d    = accum_q;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        accum_d  = '0;
                        weight_d = 32'd1;
                        cnt_d    = '0;
                    end
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MULTIRECEIVE_TIMEOUT_EN
        if (busy_q && !accept) gap_d = gap_q + 1'b1;
        // Re-arming from IDLE is the enabled low->high event that clears the sticky flag.
        if (state_q == IDLE && enabled) err_d = 1'b0;
        if (busy_q && !accept && !done_d && gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
            err_d    = 1'b1;
            accum_d  = '0;
            weight_d = 32'd1;
            cnt_d    = '0;
            busy_d   = 1'b0;
            gap_d    = '0;
            state_d  = WAIT_LOW;
        end
`endif

        // Disarming overrides everything: the partial frame is dropped, num is kept.
        if (!enabled) begin
            state_d  = IDLE;
            accum_d  = '0;
            weight_d = 32'd1;
            cnt_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            num_d    = num_q;
`ifdef MULTIRECEIVE_TIMEOUT_EN
            gap_d    = '0;
`endif
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            sym_lat_q <= '0;
            accum_q   <= '0;
            weight_q  <= 32'd1;
            cnt_q     <= '0;
            num_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            sym_lat_q <= sym_lat_d;
            accum_q   <= accum_d;
            weight_q  <= weight_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

`ifdef MULTIRECEIVE_TIMEOUT_EN
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
            err_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign num       = num_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign digit_cnt = cnt_q[2:0];

endmodule

// File: tb/tb_multireceive.sv
// Self-checking bench for multireceive: table-driven frames, hand-written corner sequences
// and random frames with injected glitches checked against a decimal reference model.
module tb_multireceive;

    localparam int NUM_DIGITS = 6;
    localparam int QUAL       = 4;
    localparam int TMO        = 200;
`ifdef MULTIRECEIVE_TIMEOUT_EN
    localparam int LONG_HOLD  = 150;
`else
    localparam int LONG_HOLD  = 500;
`endif

    logic        hwclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enabled = 1'b0;
    logic        in0 = 1'b0, in1 = 1'b0, in2 = 1'b0, controlIn = 1'b0;
    logic [31:0] num;
    logic        done, busy, err;
    logic [2:0]  digit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int   done_cnt = 0;
    logic busy_at_done = 1'b0;
    logic busy_pre_done = 1'b0;
    logic busy_prev = 1'b0;

    always #5 hwclk = ~hwclk;

    multireceive #(
        .NUM_DIGITS    (NUM_DIGITS),
        .QUAL_CYCLES   (QUAL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .hwclk    (hwclk),
        .rst_n    (rst_n),
        .enabled  (enabled),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .controlIn(controlIn),
        .num      (num),
        .done     (done),
        .busy     (busy),
        .digit_cnt(digit_cnt),
        .err      (err)
    );

    // Done-pulse monitor, sampled on the inactive edge.
    always @(negedge hwclk) begin
        if (done) begin
            done_cnt++;
            busy_at_done  = busy;
            busy_pre_done = busy_prev;
        end
        busy_prev = busy;
    end

    typedef struct {
        logic [5:0][2:0] digits;
        logic [31:0]     expv;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Frame value from the decimal rule, evaluated most-significant digit first.
    function automatic logic [31:0] model_value(input logic [5:0][2:0] d);
        logic [31:0] v = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) v = v * 32'd10 + {29'd0, d[i]};
        return v;
    endfunction

    task automatic set_in(input logic c, input logic [2:0] s);
        controlIn = c;
        {in2, in1, in0} = s;
    endtask

    // Called and returns at posedge+1.
    task automatic send_sym(input logic [2:0] s, input int hold, input int gap);
        set_in(1'b1, s);
        repeat (hold) @(posedge hwclk);
        #1;
        set_in(1'b0, 3'd0);
        repeat (gap) @(posedge hwclk);
        #1;
    endtask

    task automatic send_frame(input logic [5:0][2:0] d, input int hold, input int gap);
        for (int i = 0; i < NUM_DIGITS; i++) send_sym(d[i], hold, gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    initial begin
        int d0;
        logic [5:0][2:0] rd;

        vecs[0] = '{digits: {3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3}, expv: 32'd450123};
        vecs[1] = '{digits: {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, expv: 32'd111111};
        vecs[2] = '{digits: {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7}, expv: 32'd777777};
        vecs[3] = '{digits: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, expv: 32'd0};
        vecs[4] = '{digits: {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, expv: 32'd543210};
        vecs[5] = '{digits: {3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}, expv: 32'd100007};

        // Reset state
        repeat (3) @(posedge hwclk);
        #1;
        check("rst_num", num, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_digit_cnt", {29'd0, digit_cnt}, 0);
        check("rst_err", {31'd0, err}, 0);
        rst_n = 1'b1;
        enabled = 1'b1;
        idle(3);

        // Table of complete frames
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            send_frame(vecs[i].digits, 20, 20);
            check("tbl_num", num, vecs[i].expv);
            check("tbl_done_pulses", done_cnt - d0, 1);
            check("tbl_busy_at_done", {31'd0, busy_at_done}, 0);
            check("tbl_busy_before_done", {31'd0, busy_pre_done}, 1);
            check("tbl_digit_cnt_after", {29'd0, digit_cnt}, 0);
        end

        // Short strobe mid-frame is ignored
        d0 = done_cnt;
        send_sym(3'd1, 20, 20);
        send_sym(3'd2, 20, 20);
        send_sym(3'd7, QUAL - 1, 20);
        check("glitch_digit_cnt", {29'd0, digit_cnt}, 2);
        send_sym(3'd3, 20, 20);
        send_sym(3'd4, 20, 20);
        send_sym(3'd5, 20, 20);
        send_sym(3'd6, 20, 20);
        check("glitch_num", num, 32'd654321);
        check("glitch_done_pulses", done_cnt - d0, 1);

        // Long strobe counts once
        d0 = done_cnt;
        send_sym(3'd5, 20, 20);
        check("long_cnt_before", {29'd0, digit_cnt}, 1);
        check("long_busy", {31'd0, busy}, 1);
        send_sym(3'd6, LONG_HOLD, 20);
        check("long_cnt_after", {29'd0, digit_cnt}, 2);
        send_sym(3'd0, 20, 20);
        send_sym(3'd0, 20, 20);
        send_sym(3'd0, 20, 20);
        send_sym(3'd1, 20, 20);
        check("long_num", num, 32'd100065);
        check("long_done_pulses", done_cnt - d0, 1);

        // Disarm mid-frame, then a fresh frame
        d0 = done_cnt;
        send_sym(3'd2, 20, 20);
        send_sym(3'd2, 20, 20);
        send_sym(3'd2, 20, 20);
        enabled = 1'b0;
        idle(2);
        check("dis_busy", {31'd0, busy}, 0);
        check("dis_digit_cnt", {29'd0, digit_cnt}, 0);
        check("dis_num_held", num, 32'd100065);
        enabled = 1'b1;
        idle(2);
        for (int i = 0; i < 5; i++) send_sym(3'd1, 20, 20);
        check("dis_num_held_partial", num, 32'd100065);
        check("dis_no_spurious_done", done_cnt - d0, 0);
        send_sym(3'd1, 20, 20);
        check("dis_num_new", num, 32'd111111);
        check("dis_done_pulses", done_cnt - d0, 1);

        // Asynchronous reset mid-frame
        send_sym(3'd4, 20, 20);
        send_sym(3'd4, 20, 20);
        send_sym(3'd4, 20, 20);
        check("rstm_busy_before", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstm_num", num, 0);
        check("rstm_busy", {31'd0, busy}, 0);
        check("rstm_digit_cnt", {29'd0, digit_cnt}, 0);
        check("rstm_done", {31'd0, done}, 0);
        check("rstm_err", {31'd0, err}, 0);
        @(posedge hwclk);
        #1;
        rst_n = 1'b1;
        idle(2);
        d0 = done_cnt;
        send_frame({3'd7, 3'd6, 3'd4, 3'd2, 3'd0, 3'd2}, 20, 20);
        check("rstm_num_after", num, 32'd764202);
        check("rstm_done_pulses", done_cnt - d0, 1);

        // Random frames with injected sub-qualification glitches
        for (int f = 0; f < 10; f++) begin
            d0 = done_cnt;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                rd[i] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0)
                    send_sym(3'($urandom_range(0, 7)), $urandom_range(1, QUAL - 1), $urandom_range(8, 25));
                send_sym(rd[i], $urandom_range(QUAL + 2, 25), $urandom_range(8, 25));
            end
            idle(10);
            check("rand_num", num, model_value(rd));
            check("rand_done_pulses", done_cnt - d0, 1);
        end

        // Silence after two digits
        d0 = done_cnt;
        send_sym(3'd1, 20, 20);
        send_sym(3'd2, 20, 20);
        idle(250);
`ifdef MULTIRECEIVE_TIMEOUT_EN
        check("tmo_err", {31'd0, err}, 1);
        check("tmo_digit_cnt", {29'd0, digit_cnt}, 0);
        check("tmo_busy", {31'd0, busy}, 0);
`else
        check("tmo_err", {31'd0, err}, 0);
        check("tmo_digit_cnt", {29'd0, digit_cnt}, 2);
        check("tmo_busy", {31'd0, busy}, 1);
`endif
        check("tmo_no_done", done_cnt - d0, 0);
        check("tmo_num_held", num, model_value(rd));
        enabled = 1'b0;
        idle(2);
        enabled = 1'b1;
        idle(3);
        check("tmo_err_cleared", {31'd0, err}, 0);
        d0 = done_cnt;
        send_frame({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 20, 20);
        check("tmo_recover_num", num, 32'd123456);
        check("tmo_recover_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
